// File: rtl/caliptra_prim_unpacker_pkg.sv
// Types and constants for caliptra_prim_fifo_unpacker.
//   unpack_state_e: UnpEmpty (no word held), UnpHold (word held, chunks pending).
package caliptra_prim_unpacker_pkg;

   typedef logic [0:0] unpack_state_e;

   localparam unpack_state_e UnpEmpty = 1'b0;
   localparam unpack_state_e UnpHold  = 1'b1;

endpackage

// File: rtl/caliptra_prim_util_pkg.sv
// Shared width helpers.
//   vbits(value): number of bits needed to index `value` entries (minimum 1).
package caliptra_prim_util_pkg;

   function automatic int unsigned vbits(int unsigned value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/caliptra_prim_fifo_unpacker.sv
// Wide-to-narrow unpacker placed after caliptra_prim_fifo_sync. Accepts one InW-bit word
// per handshake and emits up to Ratio = InW/OutW chunks of OutW bits on a valid/ready port.
// A word may carry fewer than Ratio valid chunks (in_nchunk_i) and may end a packet
// (in_last_i, reflected on out_last_o with the word's final chunk).
//
// Build option: CALIPTRA_PRIM_UNPACKER_MSB_FIRST_EN selects MSB-first chunk order
// (partial words then take the top chunks). Default is LSB-first.
//
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   clr_i           synchronous flush of the held word
//   in_valid_i/in_ready_o/in_data_i/in_nchunk_i/in_last_i   word input from the FIFO
//   out_valid_o/out_ready_i/out_data_o/out_last_o           chunk output
//   busy_o          a word is held
//   err_o           one-cycle pulse after accepting an illegal in_nchunk_i
module caliptra_prim_fifo_unpacker
   import caliptra_prim_util_pkg::*;
   import caliptra_prim_unpacker_pkg::*;
#(
   parameter int unsigned  InW   = 64,
   parameter int unsigned  OutW  = 32,
   localparam int unsigned Ratio = InW / OutW,
   localparam int unsigned CntW  = vbits(Ratio + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [InW-1:0]  in_data_i,
   input  logic [CntW-1:0] in_nchunk_i,
   input  logic            in_last_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [OutW-1:0] out_data_o,
   output logic            out_last_o,
   output logic            busy_o,
   output logic            err_o
);

   localparam int unsigned IdxW = vbits(Ratio);

   if (InW % OutW != 0) begin : gen_width_check
      $error("InW must be an integer multiple of OutW");
   end
   if (Ratio < 2) begin : gen_ratio_check
      $error("InW/OutW must be at least 2");
   end

   unpack_state_e   state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [InW-1:0]  data_q, data_d;
   logic            last_q, last_d;
   logic            err_q, err_d;
   logic            under_rst_q;

   logic                       hold;
   logic                       final_chunk;
   logic                       chunk_hs;
   logic                       accept;
   logic                       nchunk_bad;
   logic [CntW-1:0]            nchunk_eff;
   logic [IdxW-1:0]            sel;
   logic [Ratio-1:0][OutW-1:0] chunks;

   assign hold        = (state_q == UnpHold);
   assign final_chunk = hold && (CntW'(idx_q) == cnt_q - CntW'(1));
   assign chunk_hs    = hold && out_ready_i;

   // Blocked during reset, the cycle after release, and while flushing.
   assign in_ready_o = rst_ni && !under_rst_q && !clr_i &&
                       (!hold || (chunk_hs && final_chunk));
   assign accept     = in_valid_i && in_ready_o;

   assign nchunk_bad = (in_nchunk_i == '0) || (in_nchunk_i > CntW'(Ratio));
   assign nchunk_eff = nchunk_bad ? CntW'(Ratio) : in_nchunk_i;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      last_d  = last_q;
      err_d   = 1'b0;
      if (clr_i) begin
         state_d = UnpEmpty;
         idx_d   = '0;
      end else if (accept) begin
         state_d = UnpHold;
         idx_d   = '0;
         cnt_d   = nchunk_eff;
         data_d  = in_data_i;
         last_d  = in_last_i;
         err_d   = nchunk_bad;
      end else if (chunk_hs) begin
         if (final_chunk) begin
            state_d = UnpEmpty;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + IdxW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= UnpEmpty;
         idx_q       <= '0;
         cnt_q       <= '0;
         data_q      <= '0;
         last_q      <= 1'b0;
         err_q       <= 1'b0;
         under_rst_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         last_q      <= last_d;
         err_q       <= err_d;
         under_rst_q <= 1'b0;
      end
   end

   assign chunks = data_q;

`ifdef CALIPTRA_PRIM_UNPACKER_MSB_FIRST_EN
   assign sel = IdxW'(Ratio - 1) - idx_q;
`else
   assign sel = idx_q;
`endif

   assign out_valid_o = hold;
   assign out_data_o  = hold ? chunks[sel] : '0;
   assign out_last_o  = final_chunk && last_q;
   assign busy_o      = hold;
   assign err_o       = err_q;

endmodule
